// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI flash responder emulating a boot flash from on-chip memory
module spi_flash_responder #(
    parameter int          ADDR_WIDTH   = 24,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
    parameter int          DUMMY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic [3:0]            qdi,
    output logic [3:0]            qdo,
    output logic [3:0]            oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    output logic                  busy,
    output logic                  cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_ID,
        S_STAT,
        S_IGNORE
    } state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    // Only io0 carries initiator data; io1..io3 are inputs we never interpret.
    logic unused_qdi;
    assign unused_qdi = ^qdi[3:1];

    logic [2:0]            sclk_sync_q;
    logic [2:0]            cs_sync_q;
    logic [1:0]            sdi_sync_q;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [22:0]           in_sh_q, in_sh_d;
    logic                  fast_q, fast_d;
    logic                  quad_q, quad_d;
    logic [7:0]            out_sh_q, out_sh_d;
    logic [2:0]            units_q, units_d;
    logic [1:0]            id_idx_q, id_idx_d;
    logic [7:0]            hold_q, hold_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [3:0]            qdo_q, qdo_d;
    logic [3:0]            oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;

    logic                  sclk_rise, sclk_fall, cs_high, cs_fall, sdi;
    logic [7:0]            cmd_word;
    logic [23:0]           addr_word;
    logic [7:0]            src_byte;
    logic [7:0]            cur_byte;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_high   = cs_sync_q[1];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign sdi       = sdi_sync_q[1];
    assign cmd_word  = {in_sh_q[6:0], sdi};
    assign addr_word = {in_sh_q, sdi};

    // Two-stage synchronizers for the async pins plus a third sclk/cs_n stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            sdi_sync_q  <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            sdi_sync_q  <= {sdi_sync_q[0], qdi[0]};
        end
    end

    // Byte presented to the output shifter when it runs empty, chosen by the active command.
    always_comb begin
        src_byte = 8'h00;
        case (state_q)
            S_DATA: src_byte = hold_q;
            S_ID: begin
                case (id_idx_q)
                    2'd0:    src_byte = JEDEC_ID[23:16];
                    2'd1:    src_byte = JEDEC_ID[15:8];
                    default: src_byte = JEDEC_ID[7:0];
                endcase
            end
            default: src_byte = 8'h00;
        endcase
    end

    // Next-state logic: command/address decode on sclk rises, output shifting on sclk falls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_sh_d    = in_sh_q;
        fast_d     = fast_q;
        quad_d     = quad_q;
        out_sh_d   = out_sh_q;
        units_d    = units_q;
        id_idx_d   = id_idx_q;
        hold_d     = rd_pend_q ? mem_data : hold_q;
        rd_pend_d  = mem_rd_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        qdo_d      = qdo_q;
        oe_d       = oe_q;
        cmd_err_d  = 1'b0;
        cur_byte   = 8'h00;
        settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // The preset cs_n=1 sync chain would fake a falling edge if reset lands mid-frame,
        // so frames are accepted only after cs_n has genuinely been seen high post-reset.
        armed_d    = armed_q | ((settle_q == 2'd3) & cs_sync_q[1] & cs_sync_q[2]);

        if (cs_high) begin
            state_d = S_IDLE;
            oe_d    = 4'b0000;
            qdo_d   = 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_d = S_CMD;
                        cnt_d   = 8'd0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        in_sh_d = {in_sh_q[21:0], sdi};
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == 8'd7) begin
                            cnt_d   = 8'd0;
                            units_d = 3'd0;
                            id_idx_d = 2'd0;
                            quad_d  = 1'b0;
                            fast_d  = 1'b0;
                            case (cmd_word)
                                8'h03: state_d = S_ADDR;
                                8'h0B: begin
                                    state_d = S_ADDR;
                                    fast_d  = 1'b1;
                                end
                                8'h6B: begin
                                    state_d = S_ADDR;
                                    fast_d  = 1'b1;
                                    quad_d  = 1'b1;
                                end
                                8'h9F: state_d = S_ID;
                                8'h05: state_d = S_STAT;
                                8'hFF: state_d = S_IGNORE;
                                default: begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        in_sh_d = {in_sh_q[21:0], sdi};
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == 8'd23) begin
                            cnt_d      = 8'd0;
                            mem_addr_d = addr_word[ADDR_WIDTH-1:0];
                            if (fast_q) begin
                                state_d = S_DUMMY;
                            end else begin
                                state_d  = S_DATA;
                                mem_rd_d = 1'b1;
                            end
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d    = 8'd0;
                            state_d  = S_DATA;
                            mem_rd_d = 1'b1;
                        end
                    end
                end
                S_DATA, S_ID, S_STAT: begin
                    if (sclk_fall) begin
                        if (units_q == 3'd0) begin
                            cur_byte = src_byte;
                            if (state_q == S_DATA) begin
                                mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                                mem_rd_d   = 1'b1;
                            end
                            if (state_q == S_ID) begin
                                id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                            end
                        end else begin
                            cur_byte = out_sh_q;
                        end
                        if (quad_q) begin
                            qdo_d    = cur_byte[7:4];
                            out_sh_d = {cur_byte[3:0], 4'b0000};
                            units_d  = (units_q == 3'd0) ? 3'd1 : units_q - 3'd1;
                            oe_d     = 4'b1111;
                        end else begin
                            qdo_d    = {2'b00, cur_byte[7], 1'b0};
                            out_sh_d = {cur_byte[6:0], 1'b0};
                            units_d  = (units_q == 3'd0) ? 3'd7 : units_q - 3'd1;
                            oe_d     = 4'b0010;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            in_sh_q    <= 23'd0;
            fast_q     <= 1'b0;
            quad_q     <= 1'b0;
            out_sh_q   <= 8'h00;
            units_q    <= 3'd0;
            id_idx_q   <= 2'd0;
            hold_q     <= 8'h00;
            rd_pend_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            qdo_q      <= 4'b0000;
            oe_q       <= 4'b0000;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_sh_q    <= in_sh_d;
            fast_q     <= fast_d;
            quad_q     <= quad_d;
            out_sh_q   <= out_sh_d;
            units_q    <= units_d;
            id_idx_q   <= id_idx_d;
            hold_q     <= hold_d;
            rd_pend_q  <= rd_pend_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            qdo_q      <= qdo_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    assign qdo      = qdo_q;
    assign oe       = oe_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - randomized self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

    localparam logic [23:0] JEDEC = 24'hEF4016;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic [3:0]  qdi = 4'h0;
    logic [3:0]  qdo;
    logic [3:0]  oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        busy;
    logic        cmd_err;

    int          checks = 0;
    int          failures = 0;

    logic [3:0]  oe_acc = 4'h0;
    logic        busy_acc = 1'b0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    logic [23:0] rd_addrs[$];
    logic [3:0]  last_oe = 4'h0;

    spi_flash_responder #(
        .ADDR_WIDTH  (24),
        .JEDEC_ID    (JEDEC),
        .DUMMY_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .qdi     (qdi),
        .qdo     (qdo),
        .oe      (oe),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .mem_data(mem_data),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    // Memory model (byte = low address byte ^ 0x5A) and activity monitor.
    always @(negedge clk) begin
        oe_acc   = oe_acc | oe;
        busy_acc = busy_acc | busy;
        if (cmd_err) err_cnt++;
        if (mem_rd) begin
            rd_cnt++;
            rd_addrs.push_back(mem_addr);
            mem_data = mem_addr[7:0] ^ 8'h5A;
        end
    end

    function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr, input int i);
        logic [23:0] a;
        logic [23:0] id;
        id = JEDEC;
        a  = addr + 24'(i);
        case (cmd)
            8'h9F:   model_byte = id[23 - 8 * (i % 3) -: 8];
            8'h05:   model_byte = 8'h00;
            default: model_byte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        oe_acc   = 4'h0;
        busy_acc = 1'b0;
        rd_cnt   = 0;
        err_cnt  = 0;
        rd_addrs.delete();
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end(input bit abrupt);
        if (!abrupt) wait_clk(4);
        cs_n   = 1'b1;
        qdi[0] = 1'b0;
        wait_clk(6);
    endtask

    // One mode-0 sclk period: data set with sclk low, output sampled just before the rise.
    task automatic sclk_cycle(input logic mosi, output logic [3:0] q);
        qdi[0] = mosi;
        wait_clk(4);
        q       = qdo;
        last_oe = oe;
        sclk    = 1'b1;
        wait_clk(4);
        sclk    = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        logic [3:0] q;
        for (int i = n - 1; i >= 0; i--) sclk_cycle(v[i], q);
    endtask

    task automatic recv_byte(input bit quad, output logic [7:0] b);
        logic [3:0] q;
        b = 8'h00;
        if (quad) begin
            for (int i = 0; i < 2; i++) begin
                sclk_cycle(1'b0, q);
                b = {b[3:0], q};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                sclk_cycle(1'b0, q);
                b = {b[6:0], q[1]};
            end
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                            input bit abrupt, input string tag);
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [23:0] ea;
        logic [3:0]  exp_oe;
        bit          is_read;
        bit          quad;
        int          exp_rd;
        is_read = (cmd == 8'h03) || (cmd == 8'h0B) || (cmd == 8'h6B);
        quad    = (cmd == 8'h6B);
        exp_oe  = quad ? 4'b1111 : 4'b0010;
        frame_begin();
        clear_mon();
        send_bits({16'h0000, cmd}, 8);
        if (is_read) send_bits(addr, 24);
        if (cmd == 8'h0B || cmd == 8'h6B) send_bits(24'h0, 8);
        checks++;
        if (oe_acc !== 4'h0) begin
            failures++;
            $display("FAIL %s_oe_before_data: got %b expected 0000", tag, oe_acc);
        end
        for (int i = 0; i < nbytes; i++) begin
            recv_byte(quad, got);
            exp = model_byte(cmd, addr, i);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s_byte%0d: got %h expected %h", tag, i, got, exp);
            end
            checks++;
            if (last_oe !== exp_oe) begin
                failures++;
                $display("FAIL %s_oe%0d: got %b expected %b", tag, i, last_oe, exp_oe);
            end
        end
        checks++;
        if (busy_acc !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_in_frame: got %b expected 1", tag, busy_acc);
        end
        frame_end(abrupt);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_after: got %b expected 0", tag, busy);
        end
        checks++;
        if (err_cnt !== 0) begin
            failures++;
            $display("FAIL %s_cmd_err: got %0d expected 0", tag, err_cnt);
        end
        // Initial prefetch plus one fetch per byte entering the shifter; a trailing fall
        // after the last bit starts one more byte unless cs_n rises with it.
        exp_rd = is_read ? (abrupt ? nbytes + 1 : nbytes + 2) : 0;
        checks++;
        if (rd_cnt !== exp_rd) begin
            failures++;
            $display("FAIL %s_rd_count: got %0d expected %0d", tag, rd_cnt, exp_rd);
        end
        for (int i = 0; i < rd_addrs.size() && i < exp_rd; i++) begin
            ea = addr + 24'(i);
            checks++;
            if (rd_addrs[i] !== ea) begin
                failures++;
                $display("FAIL %s_rd_addr%0d: got %h expected %h", tag, i, rd_addrs[i], ea);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if ({qdo, oe, mem_rd, busy, cmd_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0", {qdo, oe, mem_rd, busy, cmd_err});
        end
        checks++;
        if (mem_addr !== 24'h0) begin
            failures++;
            $display("FAIL reset_mem_addr: got %h expected 000000", mem_addr);
        end
        rst = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_jedec_id();
        do_frame(8'h9F, 24'h0, 4, 1'b0, "jedec");
    endtask

    task automatic test_read_basic();
        do_frame(8'h03, 24'h000010, 4, 1'b0, "read03");
    endtask

    task automatic test_quad_wrap();
        do_frame(8'h6B, 24'hFFFFFE, 4, 1'b0, "quad_wrap");
    endtask

    task automatic test_abort_addr();
        frame_begin();
        clear_mon();
        send_bits(24'h000003, 8);
        send_bits(24'h3FF, 10);
        frame_end(1'b0);
        checks++;
        if (rd_cnt !== 0) begin
            failures++;
            $display("FAIL abort_rd: got %0d expected 0", rd_cnt);
        end
        checks++;
        if (oe_acc !== 4'h0) begin
            failures++;
            $display("FAIL abort_oe: got %b expected 0000", oe_acc);
        end
        do_frame(8'h9F, 24'h0, 3, 1'b0, "after_abort");
    endtask

    task automatic test_bad_cmd();
        frame_begin();
        clear_mon();
        send_bits(24'h000042, 8);
        send_bits(24'($urandom), 16);
        frame_end(1'b0);
        checks++;
        if (err_cnt !== 1) begin
            failures++;
            $display("FAIL bad_cmd_err_pulses: got %0d expected 1", err_cnt);
        end
        checks++;
        if (oe_acc !== 4'h0 || rd_cnt !== 0) begin
            failures++;
            $display("FAIL bad_cmd_quiet: got oe %b rd %0d expected 0000 0", oe_acc, rd_cnt);
        end
        frame_begin();
        clear_mon();
        send_bits(24'h0000FF, 8);
        send_bits(24'($urandom), 8);
        frame_end(1'b0);
        checks++;
        if (err_cnt !== 0 || oe_acc !== 4'h0 || rd_cnt !== 0) begin
            failures++;
            $display("FAIL ff_silent: got err %0d oe %b rd %0d expected 0 0000 0", err_cnt, oe_acc, rd_cnt);
        end
        do_frame(8'h05, 24'h0, 2, 1'b0, "status");
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] b;
        logic [3:0] q;
        frame_begin();
        send_bits(24'h000003, 8);
        send_bits(24'($urandom), 24);
        recv_byte(1'b0, b);
        for (int i = 0; i < 3; i++) sclk_cycle(1'b0, q);
        rst = 1'b1;
        wait_clk(1);
        checks++;
        if ({qdo, oe, mem_rd, busy, cmd_err} !== 11'd0 || mem_addr !== 24'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %b addr %h expected 0", {qdo, oe, mem_rd, busy, cmd_err}, mem_addr);
        end
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 16; i++) sclk_cycle(1'($urandom), q);
        checks++;
        if (oe_acc !== 4'h0 || rd_cnt !== 0 || busy_acc !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stays_idle: got oe %b rd %0d busy %b expected 0000 0 0", oe_acc, rd_cnt, busy_acc);
        end
        frame_end(1'b0);
        do_frame(8'h03, 24'($urandom), 3, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  cmd;
        logic [23:0] addr;
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 4))
                0:       cmd = 8'h03;
                1:       cmd = 8'h0B;
                2:       cmd = 8'h6B;
                3:       cmd = 8'h9F;
                default: cmd = 8'h05;
            endcase
            addr = 24'($urandom);
            if ($urandom_range(0, 2) == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 3));
            do_frame(cmd, addr, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_jedec_id();
        test_read_basic();
        test_quad_wrap();
        test_abort_addr();
        test_bad_cmd();
        test_reset_mid_data();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
